// File: rtl/fp_mul_wb_stage.sv
// Writeback stage behind the fp_mul datapath: fixes up NaN/overflow results, queues them
// with per-op flags in a small FIFO and accumulates sticky flags as entries are consumed.
module fp_mul_wb_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              fp_Z,
  input  logic [2:0]               r_mode,
  input  logic                     ovrf,
  input  logic                     udrf,
  input  logic                     nan,
  input  logic                     inx,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_Z,
  output logic [3:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               fflags,
  input  logic                     flags_clr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      r_mem_z   [DEPTH];
  logic [3:0]       r_mem_f   [DEPTH];
  logic [TAG_W-1:0] r_mem_t   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_fflags;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_sign;
  logic [31:0]      w_z;
  logic [3:0]       w_flags;

  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = !w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_sign    = fp_Z[31];

  // Flag order {NV,OF,UF,NX}; unknown rounding modes fall through to RNE behaviour.
  always_comb begin
    w_z     = fp_Z;
    w_flags = {2'b00, udrf, udrf | inx};
    if (nan) begin
      w_z     = 32'h7FC0_0000;
      w_flags = 4'b1000;
    end else if (ovrf) begin
      w_flags = {2'b01, udrf, 1'b1};
      case (r_mode)
        3'b001:  w_z = {w_sign, 31'h7F7F_FFFF};
        3'b010:  w_z = w_sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'b011:  w_z = w_sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: w_z = {w_sign, 8'hFF, 23'h0};
      endcase
    end
  end

  // Storage is left unreset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_z[r_wr_ptr] <= w_z;
      r_mem_f[r_wr_ptr] <= w_flags;
      r_mem_t[r_wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fflags <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_fflags <= (flags_clr ? 4'b0000 : r_fflags) | (w_pop ? out_flags : 4'b0000);
    end
  end

  assign out_Z     = r_mem_z[r_rd_ptr];
  assign out_flags = r_mem_f[r_rd_ptr];
  assign out_tag   = r_mem_t[r_rd_ptr];
  assign fflags    = r_fflags;
  assign count     = r_count;

  a_count_max:  assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));
  a_no_ovfl:    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
  a_no_udfl:    assert property (@(posedge clk) disable iff (!rst_n) !(w_pop && r_count == '0));
  a_valid_cnt:  assert property (@(posedge clk) disable iff (!rst_n) out_valid == (r_count != '0));
endmodule

// File: tb/tb_fp_mul_wb_stage.sv
// Directed plus randomized bench for fp_mul_wb_stage with a queue scoreboard and
// an independent model of occupancy and sticky flags.
module tb_fp_mul_wb_stage;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic              clk = 0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       fp_Z;
  logic [2:0]        r_mode;
  logic              ovrf, udrf, nan, inx;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_Z;
  logic [3:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        fflags;
  logic              flags_clr;
  logic [$clog2(DEPTH):0] count;

  fp_mul_wb_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_Z(fp_Z), .r_mode(r_mode), .ovrf(ovrf), .udrf(udrf), .nan(nan), .inx(inx),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_Z(out_Z),
    .out_flags(out_flags), .out_tag(out_tag), .fflags(fflags), .flags_clr(flags_clr),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      z;
    logic [3:0]       f;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t       sb[$];
  int         m_count;
  logic [3:0] m_ff;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] model_fix(input logic [31:0] z, input logic [2:0] rm,
                                            input logic ov, input logic ud, input logic nn,
                                            input logic ix);
    logic s;
    s = z[31];
    if (nn) return {32'h7FC00000, 4'b1000};
    if (ov) begin
      logic [31:0] r;
      if (rm == 3'd1)      r = s ? 32'hFF7FFFFF : 32'h7F7FFFFF;
      else if (rm == 3'd2) r = s ? 32'hFF800000 : 32'h7F7FFFFF;
      else if (rm == 3'd3) r = s ? 32'hFF7FFFFF : 32'h7F800000;
      else                 r = s ? 32'hFF800000 : 32'h7F800000;
      return {r, 1'b0, 1'b1, ud, 1'b1};
    end
    if (ud) return {z, 4'b0011};
    return {z, 3'b000, ix};
  endfunction

  // One clock: check head against scoreboard, update model, advance, check registered state.
  task automatic tick();
    exp_t       e;
    logic [35:0] fx;
    logic [3:0] nf;
    bit         pop, push;
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_count != DEPTH});
    chk("out_valid_pre", {31'b0, out_valid}, {31'b0, m_count != 0});
    pop  = (m_count != 0) && out_ready;
    push = in_valid && (m_count != DEPTH);
    e = '0;
    if (pop) begin
      e = sb.pop_front();
      chk("out_Z", out_Z, e.z);
      chk("out_flags", {28'b0, out_flags}, {28'b0, e.f});
      chk("out_tag", {28'b0, out_tag}, {28'b0, e.t});
    end
    nf = (flags_clr ? 4'b0 : m_ff) | (pop ? e.f : 4'b0);
    if (push) begin
      fx = model_fix(fp_Z, r_mode, ovrf, udrf, nan, inx);
      sb.push_back({fx[35:4], fx[3:0], in_tag});
    end
    m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    m_ff = nf;
    chk("fflags", {28'b0, fflags}, {28'b0, m_ff});
    chk("count", {29'b0, count}, m_count);
  endtask

  task automatic drive(input logic v, input logic [31:0] z, input logic [2:0] rm,
                       input logic ov, input logic ud, input logic nn, input logic ix,
                       input logic [TAG_W-1:0] t);
    in_valid = v; fp_Z = z; r_mode = rm; ovrf = ov; udrf = ud; nan = nn; inx = ix; in_tag = t;
  endtask

  initial begin
    rst_n = 0; out_ready = 0; flags_clr = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_count = 0; m_ff = 0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_fflags", {28'b0, fflags}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1: plain result, RTZ
    drive(1, 32'h41100000, 3'b001, 0, 0, 0, 0, 4'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_out_Z", out_Z, 32'h41100000);
    chk("t1_flags", {28'b0, out_flags}, 0);
    out_ready = 1;
    tick();
    chk("t1_fflags", {28'b0, fflags}, 0);
    out_ready = 0;

    // 2: overflow, negative, RDN then RUP
    drive(1, 32'hC0000000, 3'b010, 1, 0, 0, 0, 4'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rdn_Z", out_Z, 32'hFF800000);
    chk("t2_rdn_flags", {28'b0, out_flags}, 32'h5);
    out_ready = 1;
    drive(1, 32'hC0000000, 3'b011, 1, 0, 0, 0, 4'h3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rup_Z", out_Z, 32'hFF7FFFFF);
    tick();

    // 3: NaN canonicalisation
    flags_clr = 1; tick(); flags_clr = 0;
    drive(1, 32'hFFC12345, 3'b000, 0, 0, 1, 1, 4'h4);
    out_ready = 0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_Z", out_Z, 32'h7FC00000);
    chk("t3_flags", {28'b0, out_flags}, 32'h8);
    out_ready = 1;
    tick();
    chk("t3_nv", {31'b0, fflags[3]}, 1);
    out_ready = 0;

    // 4: fill, then simultaneous push/pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h3F800000 + i, 3'(i), 0, 0, 0, i[0], 4'(8 + i));
      tick();
    end
    chk("t4_in_ready", {31'b0, in_ready}, 0);
    chk("t4_count", {29'b0, count}, DEPTH);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h40000000 + i * 32'h100, 3'(i), 0, 0, 0, i[1], 4'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && m_count != 0; i++) tick();
    chk("t4_drained", m_count, 0);

    // 5: clear in the same cycle as popping an underflow entry
    out_ready = 0;
    drive(1, 32'h00000001, 3'b000, 0, 1, 0, 0, 4'h5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1; flags_clr = 1;
    tick();
    flags_clr = 0; out_ready = 0;
    chk("t5_fflags", {28'b0, fflags}, 32'h3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1), 4'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flags_clr = $urandom_range(0, 5) == 0;
      tick();
    end
    flags_clr = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1;
    for (int i = 0; i < 10 && m_count != 0; i++) tick();
    chk("rand_drained", m_count, 0);

    // 6: asynchronous reset with entries queued
    out_ready = 0;
    drive(1, 32'h12345678, 3'b000, 0, 0, 0, 1, 4'h6); tick();
    drive(1, 32'h9ABCDEF0, 3'b000, 0, 0, 0, 1, 4'h7); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1; tick(); out_ready = 0;
    drive(1, 32'h11111111, 3'b000, 0, 0, 0, 0, 4'h8); tick();
    drive(1, 32'h22222222, 3'b000, 0, 0, 0, 0, 4'h9); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_pre_count", {29'b0, count}, 2);
    #2; rst_n = 0; #1;
    chk("t6_out_valid", {31'b0, out_valid}, 0);
    chk("t6_count", {29'b0, count}, 0);
    chk("t6_fflags", {28'b0, fflags}, 0);
    sb.delete(); m_count = 0; m_ff = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    tick();
    chk("t6_post_valid", {31'b0, out_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
